// File: rtl/seg_scan_pkg.sv
// Shared code points and active-high segment decode for the multiplexed 7-segment scanner.
// Segment byte order is {a,b,c,d,e,f,g,dp} with a in bit 7.
package seg_scan_pkg;

   localparam logic [3:0] CODE_ZERO  = 4'h0;
   localparam logic [3:0] CODE_ONE   = 4'h1;
   localparam logic [3:0] CODE_TWO   = 4'h2;
   localparam logic [3:0] CODE_THREE = 4'h3;
   localparam logic [3:0] CODE_FOUR  = 4'h4;
   localparam logic [3:0] CODE_FIVE  = 4'h5;
   localparam logic [3:0] CODE_SIX   = 4'h6;
   localparam logic [3:0] CODE_SEVEN = 4'h7;
   localparam logic [3:0] CODE_EIGHT = 4'h8;
   localparam logic [3:0] CODE_NINE  = 4'h9;
   localparam logic [3:0] CODE_DP    = 4'hA;
   localparam logic [3:0] CODE_BLANK = 4'hB;
   localparam logic [3:0] CODE_MINUS = 4'hC;
   localparam logic [3:0] CODE_D     = 4'hD;
   localparam logic [3:0] CODE_L     = 4'hE;
   localparam logic [3:0] CODE_OFF   = 4'hF;

   localparam logic [7:0] SEG_TABLE [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'h01, 8'h00, 8'h02, 8'h7A, 8'h1C, 8'h00
   };

   function automatic logic [7:0] seg_decode(input logic [3:0] code);
      return SEG_TABLE[code];
   endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1, flags the terminal count and the
// anti-ghost blank window at the start of each slot.
module seg_scan_prescaler #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   output logic tick,
   output logic in_blank
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   generate
      if (BLANK_CYC == 0) begin : g_no_blank
         assign in_blank = 1'b0;
      end else begin : g_blank
         localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
         assign in_blank = (cnt_q < BLANK_LIM);
      end
   endgenerate

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: digit index, per-frame input shadow, leading-zero
// suppression and registered select/segment drive. Optional blink via SEG_BLINK_EN.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int DIGITS     = 8,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16,
   parameter int SEL_ACT_HI = 1,
   parameter int SEG_ACT_HI = 1
`ifdef SEG_BLINK_EN
   , parameter int BLINK_FRAMES = 64
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   disp_data,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  lz_suppress,
`ifdef SEG_BLINK_EN
   input  logic [DIGITS-1:0]     blink_mask,
`endif
   output logic [DIGITS-1:0]     sel,
   output logic [7:0]            seg,
   output logic                  frame_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] SEL_IDLE = (SEL_ACT_HI != 0) ? '0 : '1;
   localparam logic [7:0]        SEG_IDLE = (SEG_ACT_HI != 0) ? 8'h00 : 8'hFF;

   logic tick, in_blank, last_slot, load, blink_blank;
   logic first_q;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   sh_data_q, sh_data_d;
   logic [DIGITS-1:0]     sh_dp_q, sh_dp_d, sh_en_q, sh_en_d;
   logic [DIGITS-1:0]     lz_blank, sel_raw, sel_d, sel_q;
   logic [7:0]            seg_raw, seg_d, seg_q;
   logic [3:0]            cur_code;

   seg_scan_prescaler #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_presc (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .in_blank (in_blank)
   );

   assign last_slot  = (idx_q == IDX_LAST);
   assign frame_done = tick & last_slot;
   // first_q makes the very first clock after reset capture the inputs
   assign load       = first_q | frame_done;

   always_comb begin
      idx_d     = idx_q;
      sh_data_d = sh_data_q;
      sh_dp_d   = sh_dp_q;
      sh_en_d   = sh_en_q;
      if (tick) idx_d = last_slot ? '0 : idx_q + 1'b1;
      if (load) begin
         sh_data_d = disp_data;
         sh_dp_d   = dp_mask;
         sh_en_d   = digit_en;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         first_q   <= 1'b1;
         idx_q     <= '0;
         sh_data_q <= '0;
         sh_dp_q   <= '0;
         sh_en_q   <= '0;
      end else begin
         first_q   <= 1'b0;
         idx_q     <= idx_d;
         sh_data_q <= sh_data_d;
         sh_dp_q   <= sh_dp_d;
         sh_en_q   <= sh_en_d;
      end
   end

`ifdef SEG_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   logic [DIGITS-1:0] sh_blink_q, sh_blink_d;
   logic [FW-1:0]     frm_q, frm_d;
   logic              phase_q, phase_d;

   always_comb begin
      sh_blink_d = load ? blink_mask : sh_blink_q;
      frm_d      = frm_q;
      phase_d    = phase_q;
      if (frame_done) begin
         if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_blink_q <= '0;
         frm_q      <= '0;
         phase_q    <= 1'b0;
      end else begin
         sh_blink_q <= sh_blink_d;
         frm_q      <= frm_d;
         phase_q    <= phase_d;
      end
   end

   assign blink_blank = phase_q & sh_blink_q[idx_q];
`else
   assign blink_blank = 1'b0;
`endif

   // Walk from the most significant digit down; a disabled digit never ends suppression
   always_comb begin
      logic       higher_ok;
      logic [3:0] code_i;
      lz_blank  = '0;
      higher_ok = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         code_i      = sh_data_q[4*i +: 4];
         lz_blank[i] = lz_suppress && (i != 0) && (code_i == CODE_ZERO) && higher_ok;
         higher_ok   = higher_ok && ((code_i == CODE_ZERO) || !sh_en_q[i]);
      end
   end

   always_comb begin
      cur_code = sh_data_q[{idx_q, 2'b00} +: 4];
      sel_raw  = DIGITS'(1) << idx_q;
      seg_raw  = seg_decode(cur_code) | {7'b0, sh_dp_q[idx_q]};
      if (!sh_en_q[idx_q] || lz_blank[idx_q] || blink_blank) seg_raw = 8'h00;
      if (in_blank) begin
         sel_raw = '0;
         seg_raw = 8'h00;
      end
      sel_d = (SEL_ACT_HI != 0) ? sel_raw : ~sel_raw;
      seg_d = (SEG_ACT_HI != 0) ? seg_raw : ~seg_raw;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_q <= SEL_IDLE;
         seg_q <= SEG_IDLE;
      end else begin
         sel_q <= sel_d;
         seg_q <= seg_d;
      end
   end

   assign sel = sel_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, plus an
// inverted-polarity instance. Expected segment patterns are hand-decoded per frame.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] disp_data, disp_inv;
   logic [3:0]  dp_mask, digit_en;
   logic        lz_suppress;
   logic [3:0]  sel, sel_n;
   logic [7:0]  seg, seg_n;
   logic        fd, fd_n;
`ifdef SEG_BLINK_EN
   logic [3:0]  blink_mask = 4'b0000;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .SEL_ACT_HI(1), .SEG_ACT_HI(1)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .disp_data   (disp_data),
      .dp_mask     (dp_mask),
      .digit_en    (digit_en),
      .lz_suppress (lz_suppress),
`ifdef SEG_BLINK_EN
      .blink_mask  (blink_mask),
`endif
      .sel         (sel),
      .seg         (seg),
      .frame_done  (fd)
   );

   seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .SEL_ACT_HI(0), .SEG_ACT_HI(0)) u_inv (
      .clk         (clk),
      .reset       (reset),
      .disp_data   (disp_inv),
      .dp_mask     (4'b0000),
      .digit_en    (4'b1111),
      .lz_suppress (lz_suppress),
`ifdef SEG_BLINK_EN
      .blink_mask  (blink_mask),
`endif
      .sel         (sel_n),
      .seg         (seg_n),
      .frame_done  (fd_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full frame (16 clocks) starting right after a frame boundary.
   task automatic run_frame(input string name, input bit do_chk,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input bit mid, input logic [15:0] mid_data);
      logic [7:0] exp_seg [4];
      logic [3:0] exp_sel;
      int slot, pos;
      exp_seg = '{e0, e1, e2, e3};
      for (int s = 0; s < 16; s++) begin
         @(posedge clk);
         @(negedge clk);
         slot = s / 4;
         pos  = s % 4;
         if (do_chk) begin
            exp_sel = 4'b0001;
            exp_sel = exp_sel << slot;
            if (pos == 0) exp_sel = 4'b0000;
            chk($sformatf("%s.s%0d.sel", name, s), {28'b0, sel}, {28'b0, exp_sel});
            chk($sformatf("%s.s%0d.seg", name, s), {24'b0, seg},
                {24'b0, (pos == 0) ? 8'h00 : exp_seg[slot]});
            chk($sformatf("%s.s%0d.fd", name, s), {31'b0, fd}, {31'b0, (s == 14)});
            if (s == 0) begin
               chk($sformatf("%s.inv.blank.sel", name), {28'b0, sel_n}, 32'hF);
               chk($sformatf("%s.inv.blank.seg", name), {24'b0, seg_n}, 32'hFF);
            end
            if (s == 1) begin
               chk($sformatf("%s.inv.d0.sel", name), {28'b0, sel_n}, 32'hE);
               chk($sformatf("%s.inv.d0.seg", name), {24'b0, seg_n}, 32'h01);
            end
         end
         if (mid && s == 5) disp_data = mid_data;
      end
   endtask

   initial begin
      disp_data   = 16'h4321;
      disp_inv    = 16'h0008;
      dp_mask     = 4'b0000;
      digit_en    = 4'b1111;
      lz_suppress = 1'b0;
      reset       = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.sel",   {28'b0, sel},   32'h0);
      chk("rst.seg",   {24'b0, seg},   32'h00);
      chk("rst.fd",    {31'b0, fd},    32'h0);
      chk("rst.sel_n", {28'b0, sel_n}, 32'hF);
      chk("rst.seg_n", {24'b0, seg_n}, 32'hFF);
      reset = 1'b1;

      run_frame("t1a", 1, 8'h60, 8'hDA, 8'hF2, 8'h66, 0, 16'h0);
      run_frame("t1b", 1, 8'h60, 8'hDA, 8'hF2, 8'h66, 0, 16'h0);

      lz_suppress = 1'b1;
      disp_data   = 16'h0070;
      run_frame("t2set", 0, 8'h0, 8'h0, 8'h0, 8'h0, 0, 16'h0);
      run_frame("t2a", 1, 8'hFC, 8'hE0, 8'h00, 8'h00, 0, 16'h0);
      disp_data = 16'h0000;
      run_frame("t2set", 0, 8'h0, 8'h0, 8'h0, 8'h0, 0, 16'h0);
      run_frame("t2b", 1, 8'hFC, 8'h00, 8'h00, 8'h00, 0, 16'h0);
      disp_data = 16'h5000;
      digit_en  = 4'b0111;
      run_frame("t2set", 0, 8'h0, 8'h0, 8'h0, 8'h0, 0, 16'h0);
      run_frame("t2c", 1, 8'hFC, 8'h00, 8'h00, 8'h00, 0, 16'h0);

      lz_suppress = 1'b0;
      digit_en    = 4'b1111;
      disp_data   = 16'hDCEA;
      run_frame("tdset", 0, 8'h0, 8'h0, 8'h0, 8'h0, 0, 16'h0);
      run_frame("tdec", 1, 8'h01, 8'h1C, 8'h02, 8'h7A, 0, 16'h0);

      disp_data = 16'h1111;
      run_frame("t3set", 0, 8'h0, 8'h0, 8'h0, 8'h0, 0, 16'h0);
      run_frame("t3a", 1, 8'h60, 8'h60, 8'h60, 8'h60, 1, 16'h2222);
      run_frame("t3b", 1, 8'hDA, 8'hDA, 8'hDA, 8'hDA, 0, 16'h0);

      dp_mask   = 4'b0101;
      disp_data = 16'h0B08;
      run_frame("t4set", 0, 8'h0, 8'h0, 8'h0, 8'h0, 0, 16'h0);
      run_frame("t4a", 1, 8'hFF, 8'hFC, 8'h01, 8'hFC, 0, 16'h0);
      digit_en = 4'b1011;
      run_frame("t4set", 0, 8'h0, 8'h0, 8'h0, 8'h0, 0, 16'h0);
      run_frame("t4b", 1, 8'hFF, 8'hFC, 8'h00, 8'hFC, 0, 16'h0);

      dp_mask   = 4'b0000;
      digit_en  = 4'b1111;
      disp_data = 16'h4321;
      run_frame("t6set", 0, 8'h0, 8'h0, 8'h0, 8'h0, 0, 16'h0);
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("t6.pre.sel", {28'b0, sel}, 32'h4);
      chk("t6.pre.seg", {24'b0, seg}, 32'hF2);
      #2 reset = 1'b0;
      #1;
      chk("t6.rst.sel",   {28'b0, sel},   32'h0);
      chk("t6.rst.seg",   {24'b0, seg},   32'h00);
      chk("t6.rst.fd",    {31'b0, fd},    32'h0);
      chk("t6.rst.sel_n", {28'b0, sel_n}, 32'hF);
      chk("t6.rst.seg_n", {24'b0, seg_n}, 32'hFF);
      disp_data = 16'h9876;
      @(negedge clk);
      reset = 1'b1;
      run_frame("t6", 1, 8'hBE, 8'hE0, 8'hFE, 8'hF6, 0, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
